// File: rtl/hdmux_pkg.sv
// Shared types and helpers for the hdmux_nb_sync clocked multiplexer.
package hdmux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam int BLANK_W = 4;

  // Select width: clog2 of the channel count, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hdmux_nb_core.sv
// Combinational N:1 WIDTH-bit channel select with optional park override and inversion.
// HDMUX_PARITY_EN exposes the uninverted selected word for the parity bit.
module hdmux_nb_core
  import hdmux_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 1,
  parameter int INV = 1,
  parameter logic [WIDTH-1:0] PARK_VAL = '0,
  parameter int SW = sel_w(N)
) (
  input  logic [N*WIDTH-1:0] a,
  input  logic [SW-1:0]      sel,
  input  logic               park,
`ifdef HDMUX_PARITY_EN
  output logic [WIDTH-1:0]   raw,
`endif
  output logic [WIDTH-1:0]   z
);

  logic [WIDTH-1:0] data;

  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) data = a[k*WIDTH +: WIDTH];
    end
    if (park) data = PARK_VAL;
  end

`ifdef HDMUX_PARITY_EN
  assign raw = data;
`endif
  assign z = (INV != 0) ? ~data : data;

endmodule

// File: rtl/hdmux_nb_sync.sv
// N-channel registered mux with break-before-make select switching.
// Optional parity output ZP when HDMUX_PARITY_EN is defined.
module hdmux_nb_sync
  import hdmux_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 1,
  parameter int BLANK_CYC = 1,
  parameter int INV = 1,
  parameter logic [WIDTH-1:0] PARK_VAL = '0,
  localparam int SW = sel_w(N)
) (
  input  logic               CK,
  input  logic               RN,
  input  logic [N*WIDTH-1:0] A,
  input  logic [SW-1:0]      SL,
  input  logic               SL_REQ,
  output logic               SL_ACK,
  output logic               BUSY,
  output logic               VLD,
  output logic [WIDTH-1:0]   Z,
`ifdef HDMUX_PARITY_EN
  output logic               ZP,
`endif
  output logic [1:0]         dbg_state
);

  localparam logic [WIDTH-1:0] PARK_Z = (INV != 0) ? ~PARK_VAL : PARK_VAL;

  state_t             state;
  logic [SW-1:0]      cur_sel;
  logic [SW-1:0]      nxt_sel;
  logic [BLANK_W-1:0] cnt;
  logic [SW-1:0]      mux_sel;
  logic [WIDTH-1:0]   z_next;
`ifdef HDMUX_PARITY_EN
  logic [WIDTH-1:0]   raw;
`endif

  // The switching cycle already drives the new channel so it is live when ACK is.
  assign mux_sel   = (state == SWITCH) ? nxt_sel : cur_sel;
  assign dbg_state = state;

  hdmux_nb_core #(
    .N(N), .WIDTH(WIDTH), .INV(INV), .PARK_VAL(PARK_VAL), .SW(SW)
  ) u_core (
    .a(A),
    .sel(mux_sel),
    .park(state == BLANK),
`ifdef HDMUX_PARITY_EN
    .raw(raw),
`endif
    .z(z_next)
  );

  // Handshake: SL/SL_REQ are sampled only while BUSY=0; the requester holds
  // SL_REQ until SL_ACK, which pulses for one cycle once the target is live on Z.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      cur_sel <= '0;
      nxt_sel <= '0;
      cnt     <= '0;
      Z       <= PARK_Z;
      VLD     <= 1'b0;
      BUSY    <= 1'b0;
      SL_ACK  <= 1'b0;
`ifdef HDMUX_PARITY_EN
      ZP      <= ^PARK_VAL;
`endif
    end else begin
      Z      <= z_next;
      SL_ACK <= 1'b0;
`ifdef HDMUX_PARITY_EN
      ZP     <= ^raw;
`endif
      case (state)
        IDLE: begin
          VLD <= 1'b1;
          if (SL_REQ && (32'(SL) < N)) begin
            if (SL == cur_sel) begin
              SL_ACK <= 1'b1;
            end else begin
              nxt_sel <= SL;
              BUSY    <= 1'b1;
              if (BLANK_CYC > 0) begin
                state <= BLANK;
                cnt   <= BLANK_W'(BLANK_CYC - 1);
              end else begin
                state <= SWITCH;
              end
            end
          end
        end
        BLANK: begin
          VLD <= 1'b0;
          if (cnt == '0) state <= SWITCH;
          else           cnt   <= cnt - 1'b1;
        end
        SWITCH: begin
          VLD     <= 1'b1;
          SL_ACK  <= 1'b1;
          BUSY    <= 1'b0;
          cur_sel <= nxt_sel;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmux_nb_sync.sv
// Bench for hdmux_nb_sync: directed handshake scenarios followed by random traffic,
// checked against a timing-rule reference model.
module tb_hdmux_nb_sync;

  localparam int N = 3;
  localparam int W = 8;
  localparam int B = 2;
  localparam int INV = 1;
  localparam logic [W-1:0] PV = 8'h00;

  logic           CK = 1'b0;
  logic           RN = 1'b1;
  logic [N*W-1:0] A;
  logic [1:0]     SL;
  logic           SL_REQ;
  logic           SL_ACK, BUSY, VLD;
  logic [W-1:0]   Z;
  logic [1:0]     dbg_state;
`ifdef HDMUX_PARITY_EN
  logic           ZP;
`endif

  hdmux_nb_sync #(
    .N(N), .WIDTH(W), .BLANK_CYC(B), .INV(INV), .PARK_VAL(PV)
  ) dut (
    .CK(CK), .RN(RN), .A(A), .SL(SL), .SL_REQ(SL_REQ),
    .SL_ACK(SL_ACK), .BUSY(BUSY), .VLD(VLD), .Z(Z),
`ifdef HDMUX_PARITY_EN
    .ZP(ZP),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CK = ~CK;

  int vectors = 0;
  int miscompares = 0;

  // reference model: request edge is offset 0, offsets 1..B are parked,
  // offset B+1 shows the new channel with ACK
  int           m_sel, m_tgt, m_d;
  bit           m_busy;
  logic [W-1:0] e_z;
  logic         e_vld, e_busy, e_ack, e_zp;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] chan(input int k);
    return A[k*W +: W];
  endfunction

  function automatic logic [W-1:0] drive(input logic [W-1:0] d);
    return (INV != 0) ? ~d : d;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_busy = 0; m_d = 0; m_tgt = 0;
    e_z = drive(PV); e_vld = 0; e_busy = 0; e_ack = 0; e_zp = ^PV;
    exp_q.push_back(e_z);
  endtask

  task automatic model_edge();
    logic [W-1:0] d;
    e_ack = 0;
    if (!m_busy) begin
      d = chan(m_sel);
      e_vld = 1;
      if (SL_REQ && int'(SL) < N) begin
        if (int'(SL) == m_sel) e_ack = 1;
        else begin m_busy = 1; m_tgt = int'(SL); m_d = 0; end
      end
    end else begin
      m_d++;
      if (m_d <= B) begin
        d = PV; e_vld = 0;
      end else begin
        m_sel = m_tgt; m_busy = 0;
        d = chan(m_sel); e_vld = 1; e_ack = 1;
      end
    end
    e_busy = m_busy;
    e_z = drive(d);
    e_zp = ^d;
    exp_q.push_back(e_z);
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] ez;
    ez = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("z", Z, ez);
    chk("vld", W'(VLD), W'(e_vld));
    chk("busy", W'(BUSY), W'(e_busy));
    chk("ack", W'(SL_ACK), W'(e_ack));
`ifdef HDMUX_PARITY_EN
    chk("zp", W'(ZP), W'(e_zp));
`endif
  endtask

  // driver: one clock, model update on the edge, sample 1 time unit later
  task automatic step();
    @(posedge CK);
    if (RN) model_edge();
    else    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    A = {8'h22, 8'h11, 8'hA5};
    SL = 2'd0;
    SL_REQ = 1'b0;
    #1 RN = 1'b0;
    #1 model_reset();
    compare_all();
    chk("z_in_reset", Z, 8'hFF);
    step(); step();
    RN = 1'b1;
    step();
    chk("z_release", Z, 8'h5A);

    // distinct select with blanking
    SL = 2'd2; SL_REQ = 1'b1;
    step();
    SL_REQ = 1'b0;
    step(); chk("z_blank1", Z, 8'hFF);
    step(); chk("z_blank2", Z, 8'hFF);
    step(); chk("z_switch", Z, 8'hDD); chk("ack_latency", W'(SL_ACK), 8'h01);
    step();

    // same select: ack without blanking
    SL = 2'd2; SL_REQ = 1'b1;
    step();
    SL_REQ = 1'b0;
    step();

    // out of range
    SL = 2'd3; SL_REQ = 1'b1;
    step();
    SL_REQ = 1'b0;
    step();

    // request while busy is ignored; A changes during blanking
    SL = 2'd0; SL_REQ = 1'b1;
    step();
    SL = 2'd1;
    A = {8'h5C, 8'h3E, 8'h81};
    step();
    SL_REQ = 1'b0;
    A = {8'h6D, 8'h4F, 8'h92};
    step(); step(); step();
    chk("z_first_target", Z, 8'h6D);

    // reset in the middle of blanking
    SL = 2'd1; SL_REQ = 1'b1;
    step();
    SL_REQ = 1'b0;
    step();
    #2 RN = 1'b0;
    #1 model_reset();
    compare_all();
    step();
    RN = 1'b1;
    step(); step();
    chk("z_after_abort", Z, ~A[7:0]);

    // random traffic with occasional asynchronous resets
    repeat (400) begin
      A = {$urandom, $urandom};
      SL = 2'($urandom_range(0, 3));
      SL_REQ = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        RN = 1'b0;
        #1 model_reset();
        compare_all();
      end else begin
        RN = 1'b1;
      end
      step();
    end

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
